// File: rtl/pipe_stall_ctrl_if.sv
// pipe_stall_ctrl_if
// Groups the hazard-control, fetch and decode signals that the front-end stall
// controller consumes, plus the pipeline-register views it produces.
//   Inputs to the controller : start_i, pc_next_i, instr_i, PC_Write,
//                              IF_ID_Write, NOP, flush_i, ctrl_i
//   Outputs from controller  : pc_o, if_id_instr_o, if_id_pc4_o, id_ex_ctrl_o,
//                              bubble_cnt_o, stall_err_o
// Modports: master drives the controller inputs (hazard unit / fetch side),
//           slave is the controller itself.
interface pipe_stall_ctrl_if #(
    parameter int unsigned CTRL_W = 8,
    parameter int unsigned CNT_W  = 16
);
    logic              start_i;
    logic [31:0]       pc_next_i;
    logic [31:0]       instr_i;
    logic              PC_Write;
    logic              IF_ID_Write;
    logic              NOP;
    logic              flush_i;
    logic [CTRL_W-1:0] ctrl_i;

    logic [31:0]       pc_o;
    logic [31:0]       if_id_instr_o;
    logic [31:0]       if_id_pc4_o;
    logic [CTRL_W-1:0] id_ex_ctrl_o;
    logic [CNT_W-1:0]  bubble_cnt_o;
    logic              stall_err_o;

    modport master (
        output start_i, pc_next_i, instr_i, PC_Write, IF_ID_Write, NOP,
               flush_i, ctrl_i,
        input  pc_o, if_id_instr_o, if_id_pc4_o, id_ex_ctrl_o,
               bubble_cnt_o, stall_err_o
    );

    modport slave (
        input  start_i, pc_next_i, instr_i, PC_Write, IF_ID_Write, NOP,
               flush_i, ctrl_i,
        output pc_o, if_id_instr_o, if_id_pc4_o, id_ex_ctrl_o,
               bubble_cnt_o, stall_err_o
    );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl
// Consumer end of the load-use hazard interface. Owns the PC register, the
// IF/ID pipeline register and the control half of ID/EX, and applies the
// PC_Write / IF_ID_Write / NOP decisions of the hazard detector to them.
// Also provides branch squash of IF/ID, a saturating bubble counter and a
// sticky flag raised when a stall lasts longer than MAX_STALL cycles.
// Ports:
//   clk_i  : clock, all state updates on the rising edge
//   rst_i  : asynchronous active-low reset, clears all state
//   bus    : pipe_stall_ctrl_if.slave (see interface header for signals)
// All outputs are registered; nothing changes while start_i is low.
module pipe_stall_ctrl #(
    parameter int unsigned CTRL_W    = 8,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned MAX_STALL = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    pipe_stall_ctrl_if.slave bus
);
    // Run counter must be able to hold MAX_STALL + 1 (its saturation value).
    localparam int unsigned      RUN_W   = $clog2(MAX_STALL + 2);
    localparam logic [RUN_W-1:0] RUN_SAT = RUN_W'(MAX_STALL + 1);
    localparam logic [RUN_W-1:0] RUN_LIM = RUN_W'(MAX_STALL);

    logic [31:0]       pc_q;
    logic [31:0]       instr_q;
    logic [31:0]       pc4_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic [CNT_W-1:0]  bub_q;
    logic [RUN_W-1:0]  run_q;
    logic              err_q;

    // PC and IF/ID. A flush in a stalled ID is ignored because the branch
    // decision there is not yet valid; only a writing IF/ID can be squashed.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pc_q    <= '0;
            instr_q <= '0;
            pc4_q   <= '0;
        end else if (bus.start_i) begin
            if (bus.PC_Write) begin
                pc_q <= bus.pc_next_i;
            end
            if (bus.IF_ID_Write) begin
                instr_q <= bus.flush_i ? '0 : bus.instr_i;
                pc4_q   <= pc_q + 32'd4;
            end
        end
    end

    // ID/EX control: always advances, bubble replaces the bundle with zero.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ctrl_q <= '0;
        end else if (bus.start_i) begin
            ctrl_q <= bus.NOP ? '0 : bus.ctrl_i;
        end
    end

    // Bubble statistics. The run counter saturates one past the limit so it
    // can never wrap back into the legal range during a very long stall; the
    // error flag fires on the edge whose bubble makes the run exceed the limit.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            bub_q <= '0;
            run_q <= '0;
            err_q <= 1'b0;
        end else if (bus.start_i) begin
            if (bus.NOP) begin
                if (bub_q != '1) begin
                    bub_q <= bub_q + CNT_W'(1);
                end
                if (run_q != RUN_SAT) begin
                    run_q <= run_q + RUN_W'(1);
                end
                if (run_q >= RUN_LIM) begin
                    err_q <= 1'b1;
                end
            end else begin
                run_q <= '0;
            end
        end
    end

    assign bus.pc_o          = pc_q;
    assign bus.if_id_instr_o = instr_q;
    assign bus.if_id_pc4_o   = pc4_q;
    assign bus.id_ex_ctrl_o  = ctrl_q;
    assign bus.bubble_cnt_o  = bub_q;
    assign bus.stall_err_o   = err_q;
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb_pipe_stall_ctrl
// Bench for pipe_stall_ctrl: a directed vector table, hand-written sequences
// for reset, long stalls, saturation and wrap, then randomized cycles checked
// against a behavioural model. A second instance with a 2-bit bubble counter
// shares the stimulus to exercise counter saturation.
module tb_pipe_stall_ctrl;
    localparam int unsigned CTRL_W    = 8;
    localparam int unsigned CNT_W     = 16;
    localparam int unsigned MAX_STALL = 1;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    always #5 clk_i = ~clk_i;

    pipe_stall_ctrl_if #(.CTRL_W(CTRL_W), .CNT_W(CNT_W)) bus ();
    pipe_stall_ctrl_if #(.CTRL_W(CTRL_W), .CNT_W(2))     sbus ();

    pipe_stall_ctrl #(.CTRL_W(CTRL_W), .CNT_W(CNT_W), .MAX_STALL(MAX_STALL)) u_dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    pipe_stall_ctrl #(.CTRL_W(CTRL_W), .CNT_W(2), .MAX_STALL(MAX_STALL)) u_small (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (sbus)
    );

    assign sbus.start_i     = bus.start_i;
    assign sbus.pc_next_i   = bus.pc_next_i;
    assign sbus.instr_i     = bus.instr_i;
    assign sbus.PC_Write    = bus.PC_Write;
    assign sbus.IF_ID_Write = bus.IF_ID_Write;
    assign sbus.NOP         = bus.NOP;
    assign sbus.flush_i     = bus.flush_i;
    assign sbus.ctrl_i      = bus.ctrl_i;

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    logic [31:0] m_pc, m_instr, m_pc4;
    logic [7:0]  m_ctrl;
    int          m_bub, m_bub_small, m_run;
    bit          m_err;

    typedef struct {
        bit          start, pcw, ifw, nop, flush;
        logic [31:0] pc_next, instr;
        logic [7:0]  ctrl;
        logic [31:0] e_pc, e_instr, e_pc4;
        logic [7:0]  e_ctrl;
        int          e_bub;
        bit          e_err;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        m_pc = '0; m_instr = '0; m_pc4 = '0; m_ctrl = '0;
        m_bub = 0; m_bub_small = 0; m_run = 0; m_err = 1'b0;
    endtask

    // One rising edge as described by the rules: fields update independently.
    task automatic model_edge();
        logic [31:0] old_pc;
        if (!bus.start_i) return;
        old_pc = m_pc;
        if (bus.PC_Write) m_pc = bus.pc_next_i;
        if (bus.IF_ID_Write) begin
            m_instr = bus.flush_i ? 32'd0 : bus.instr_i;
            m_pc4   = old_pc + 32'd4;
        end
        m_ctrl = bus.NOP ? 8'd0 : bus.ctrl_i;
        if (bus.NOP) begin
            m_bub       = (m_bub + 1 > 65535) ? 65535 : m_bub + 1;
            m_bub_small = (m_bub_small + 1 > 3) ? 3 : m_bub_small + 1;
            m_run++;
            if (m_run > MAX_STALL) m_err = 1'b1;
        end else begin
            m_run = 0;
        end
    endtask

    // Inputs are changed right after a falling edge; outputs are sampled on the next one.
    task automatic tick();
        @(posedge clk_i);
        model_edge();
        @(negedge clk_i);
    endtask

    task automatic set_in(input bit start, input bit pcw, input bit ifw, input bit nop,
                          input bit flush, input logic [31:0] pc_next,
                          input logic [31:0] instr, input logic [7:0] ctrl);
        bus.start_i = start; bus.PC_Write = pcw; bus.IF_ID_Write = ifw; bus.NOP = nop;
        bus.flush_i = flush; bus.pc_next_i = pc_next; bus.instr_i = instr; bus.ctrl_i = ctrl;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_pc"},    bus.pc_o, 32'd0);
        chk({tag, "_instr"}, bus.if_id_instr_o, 32'd0);
        chk({tag, "_pc4"},   bus.if_id_pc4_o, 32'd0);
        chk({tag, "_ctrl"},  32'(bus.id_ex_ctrl_o), 32'd0);
        chk({tag, "_bub"},   32'(bus.bubble_cnt_o), 32'd0);
        chk({tag, "_sbub"},  32'(sbus.bubble_cnt_o), 32'd0);
        chk({tag, "_err"},   32'(bus.stall_err_o), 32'd0);
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_pc"},    bus.pc_o, m_pc);
        chk({tag, "_instr"}, bus.if_id_instr_o, m_instr);
        chk({tag, "_pc4"},   bus.if_id_pc4_o, m_pc4);
        chk({tag, "_ctrl"},  32'(bus.id_ex_ctrl_o), 32'(m_ctrl));
        chk({tag, "_bub"},   32'(bus.bubble_cnt_o), 32'(m_bub));
        chk({tag, "_sbub"},  32'(sbus.bubble_cnt_o), 32'(m_bub_small));
        chk({tag, "_err"},   32'(bus.stall_err_o), 32'(m_err));
    endtask

    // Called at a falling edge: reset asserted mid-cycle, checked while held.
    task automatic do_reset(input string tag);
        #2 rst_i = 1'b0;
        model_clear();
        #1 check_zero(tag);
        @(negedge clk_i);
        rst_i = 1'b1;
    endtask

    initial begin
        set_in(0, 0, 0, 0, 0, 32'd0, 32'd0, 8'd0);
        model_clear();

        // Reset mid-cycle, held across edges with active toggling inputs
        #2 rst_i = 1'b0;
        #1 check_zero("rst_async");
        set_in(1, 1, 1, 1, 1, 32'hFFFF_0000, 32'h1234_5678, 8'h5A);
        @(negedge clk_i);
        check_zero("rst_held1");
        set_in(1, 1, 1, 0, 0, 32'h0000_0444, 32'h8765_4321, 8'hA5);
        @(negedge clk_i);
        check_zero("rst_held2");
        rst_i = 1'b1;

        //          st pw iw np fl pc_next        instr          ctrl   e_pc           e_instr        e_pc4          e_ctrl bub err
        vecs[0] = '{1, 1, 1, 0, 0, 32'h0000_0004, 32'h1111_0000, 8'h01, 32'h0000_0004, 32'h1111_0000, 32'h0000_0004, 8'h01, 0, 0};
        vecs[1] = '{1, 1, 1, 0, 0, 32'h0000_0008, 32'h2222_0000, 8'h02, 32'h0000_0008, 32'h2222_0000, 32'h0000_0008, 8'h02, 0, 0};
        vecs[2] = '{1, 1, 1, 0, 0, 32'h0000_000C, 32'h3333_0000, 8'h03, 32'h0000_000C, 32'h3333_0000, 32'h0000_000C, 8'h03, 0, 0};
        vecs[3] = '{1, 1, 1, 0, 0, 32'h0000_0020, 32'hAAAA_0000, 8'h04, 32'h0000_0020, 32'hAAAA_0000, 32'h0000_0010, 8'h04, 0, 0};
        vecs[4] = '{1, 0, 0, 1, 0, 32'h0000_0099, 32'hBBBB_0000, 8'hFF, 32'h0000_0020, 32'hAAAA_0000, 32'h0000_0010, 8'h00, 1, 0};
        vecs[5] = '{1, 1, 1, 0, 0, 32'h0000_0024, 32'hCCCC_0000, 8'h05, 32'h0000_0024, 32'hCCCC_0000, 32'h0000_0024, 8'h05, 1, 0};
        vecs[6] = '{1, 1, 1, 0, 1, 32'h0000_0028, 32'hDDDD_0000, 8'h06, 32'h0000_0028, 32'h0000_0000, 32'h0000_0028, 8'h06, 1, 0};
        vecs[7] = '{1, 1, 1, 0, 0, 32'h0000_002C, 32'hEEEE_0000, 8'h07, 32'h0000_002C, 32'hEEEE_0000, 32'h0000_002C, 8'h07, 1, 0};
        vecs[8] = '{1, 1, 0, 0, 1, 32'h0000_0030, 32'h1234_5678, 8'h08, 32'h0000_0030, 32'hEEEE_0000, 32'h0000_002C, 8'h08, 1, 0};
        vecs[9] = '{0, 1, 1, 1, 0, 32'hDEAD_0000, 32'hFFFF_FFFF, 8'hAA, 32'h0000_0030, 32'hEEEE_0000, 32'h0000_002C, 8'h08, 1, 0};

        for (int i = 0; i < 10; i++) begin
            set_in(vecs[i].start, vecs[i].pcw, vecs[i].ifw, vecs[i].nop, vecs[i].flush,
                   vecs[i].pc_next, vecs[i].instr, vecs[i].ctrl);
            tick();
            chk($sformatf("vec%0d_pc", i),    bus.pc_o, vecs[i].e_pc);
            chk($sformatf("vec%0d_instr", i), bus.if_id_instr_o, vecs[i].e_instr);
            chk($sformatf("vec%0d_pc4", i),   bus.if_id_pc4_o, vecs[i].e_pc4);
            chk($sformatf("vec%0d_ctrl", i),  32'(bus.id_ex_ctrl_o), 32'(vecs[i].e_ctrl));
            chk($sformatf("vec%0d_bub", i),   32'(bus.bubble_cnt_o), 32'(vecs[i].e_bub));
            chk($sformatf("vec%0d_err", i),   32'(bus.stall_err_o), 32'(vecs[i].e_err));
        end

        // Long stall: second consecutive bubble sets the sticky error
        set_in(1, 0, 0, 1, 0, 32'h0, 32'h0, 8'h33);
        tick();
        chk("long1_err", 32'(bus.stall_err_o), 32'd0);
        chk("long1_bub", 32'(bus.bubble_cnt_o), 32'd2);
        tick();
        chk("long2_err", 32'(bus.stall_err_o), 32'd1);
        chk("long2_bub", 32'(bus.bubble_cnt_o), 32'd3);
        set_in(1, 1, 1, 0, 0, 32'h40, 32'h0, 8'h33);
        tick();
        chk("long3_err", 32'(bus.stall_err_o), 32'd1);
        tick();
        chk("long4_err", 32'(bus.stall_err_o), 32'd1);
        do_reset("long_rst");
        chk("long_rst_err", 32'(bus.stall_err_o), 32'd0);

        // Saturation of the 2-bit counter over 5 bubbles
        set_in(1, 0, 0, 1, 0, 32'h0, 32'h0, 8'h11);
        for (int i = 0; i < 5; i++) tick();
        chk("sat_small", 32'(sbus.bubble_cnt_o), 32'd3);
        chk("sat_main",  32'(bus.bubble_cnt_o), 32'd5);
        chk("sat_err",   32'(bus.stall_err_o), 32'd1);

        // PC+4 wrap-around
        set_in(1, 1, 1, 0, 0, 32'hFFFF_FFFC, 32'h0101_0101, 8'h22);
        tick();
        chk("wrap_pc", bus.pc_o, 32'hFFFF_FFFC);
        set_in(1, 1, 1, 0, 0, 32'h0000_0000, 32'h0202_0202, 8'h22);
        tick();
        chk("wrap_pc4", bus.if_id_pc4_o, 32'h0000_0000);
        chk("wrap_pc2", bus.pc_o, 32'h0000_0000);

        // Freeze: start low with toggling inputs changes nothing
        for (int i = 0; i < 6; i++) begin
            set_in(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                   $urandom, $urandom, 8'($urandom));
            tick();
            chk("frz_pc",    bus.pc_o, 32'h0000_0000);
            chk("frz_instr", bus.if_id_instr_o, 32'h0202_0202);
            chk("frz_pc4",   bus.if_id_pc4_o, 32'h0000_0000);
            chk("frz_ctrl",  32'(bus.id_ex_ctrl_o), 32'h22);
            chk("frz_bub",   32'(bus.bubble_cnt_o), 32'd5);
        end

        // Reset during a stall discards the run in progress
        set_in(1, 0, 0, 1, 0, 32'h0, 32'h0, 8'h44);
        do_reset("mid_rst0");
        tick();
        do_reset("mid_rst");
        tick();
        chk("mid_err", 32'(bus.stall_err_o), 32'd0);
        chk("mid_bub", 32'(bus.bubble_cnt_o), 32'd1);
        chk("mid_ctrl", 32'(bus.id_ex_ctrl_o), 32'd0);

        // Randomized cycles against the model
        for (int blk = 0; blk < 4; blk++) begin
            do_reset("rnd_rst");
            for (int i = 0; i < 100; i++) begin
                set_in(($urandom_range(7) != 0), ($urandom_range(3) != 0),
                       ($urandom_range(3) != 0), ($urandom_range(3) == 0),
                       ($urandom_range(7) == 0), $urandom, $urandom, 8'($urandom));
                tick();
                check_model("rnd");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
